dmem_arbiter: RTL and testbench

Two-port arbiter in front of the single-port data memory. It shares the memory between the pipeline MEM stage (cpu port) and a host/debug port (host port), which the host uses for preload, IO-window polling and result readback. The CPU has fixed priority. A starvation counter gives the host a bounded wait, and an optional host lock supports multi-word bursts. The block sits between the datapath MEM stage and the dmem instance inside the top level.

---
 rtl/mips_mem_pkg.sv | 18 +
 rtl/dmem_arbiter_if.sv | 60 ++++++
 rtl/dmem_arbiter_starve_cnt.sv | 36 +++
 rtl/dmem_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_mem_pkg.sv
// Shared memory-side types for the data-memory arbiter:
// port owner and lock state enums, plus the IO-map constants.
package mips_mem_pkg;

  typedef enum logic {
    OWN_CPU  = 1'b0,
    OWN_HOST = 1'b1
  } owner_e;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_e;

  localparam logic [15:0] IN0_ADDR  = 16'd272;
  localparam logic [15:0] OUT0_ADDR = 16'd256;

endpackage

// File: rtl/dmem_arbiter_if.sv
// CPU, host and memory-side bus bundle of the data-memory arbiter.
// slave = arbiter view, master = requester/memory environment view.
interface dmem_arbiter_if #(
  parameter int AW = 10
);

  logic          cpu_req;
  logic          cpu_we;
  logic [31:0]   cpu_addr;
  logic [31:0]   cpu_wdata;
  logic [3:0]    cpu_be;
  logic          cpu_gnt;
  logic          cpu_stall;
  logic          cpu_rvalid;
  logic [31:0]   cpu_rdata;

  logic          host_req;
  logic          host_we;
  logic [31:0]   host_addr;
  logic [31:0]   host_wdata;
  logic [3:0]    host_be;
  logic          host_lock;
  logic          host_gnt;
  logic          host_rvalid;
  logic [31:0]   host_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_be;
  logic [31:0]   mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr,
    input  cpu_wdata, cpu_be,
    output cpu_gnt, cpu_stall,
    output cpu_rvalid, cpu_rdata,
    input  host_req, host_we, host_addr,
    input  host_wdata, host_be, host_lock,
    output host_gnt, host_rvalid, host_rdata,
    output mem_en, mem_we, mem_addr,
    output mem_wdata, mem_be,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr,
    output cpu_wdata, cpu_be,
    input  cpu_gnt, cpu_stall,
    input  cpu_rvalid, cpu_rdata,
    output host_req, host_we, host_addr,
    output host_wdata, host_be, host_lock,
    input  host_gnt, host_rvalid, host_rdata,
    input  mem_en, mem_we, mem_addr,
    input  mem_wdata, mem_be,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_arbiter_starve_cnt.sv
// Saturating host starvation counter; at_max forces a host grant.
module arb_starve_cnt #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int W = $clog2(MAX + 1);
  localparam logic [W-1:0] MAXV = W'(MAX);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && cnt_q != MAXV) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max = (cnt_q == MAXV);

endmodule

// File: rtl/dmem_arbiter.sv
// CPU/host arbiter for the single-port dmem, fixed CPU priority,
// bounded host wait and host lock bursts. Option: DMEM_ARB_STATS_EN.
module dmem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int AW       = 10,
  parameter int MAX_WAIT = 4,
  parameter int MAX_LOCK = 16
) (
  input  logic clk,
  input  logic rst,
  dmem_arbiter_if.slave bus
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0] conflict_cnt,
  output logic [15:0] forced_cnt
`endif
);

  localparam int LW = $clog2(MAX_LOCK + 1);
  localparam logic [LW-1:0] LOCK_LAST =
    LW'(MAX_LOCK - 1);

  lock_e          lock_q, lock_d;
  logic [LW-1:0]  lock_cnt_q, lock_cnt_d;
  logic           yield_q, yield_d;
  logic           resume_q, resume_d;
  logic           rd_pend_q, rd_pend_d;
  owner_e         rd_owner_q, rd_owner_d;
  logic [31:0]    cpu_rdata_q, cpu_rdata_d;
  logic [31:0]    host_rdata_q, host_rdata_d;

  logic both, lock_active, at_max;
  logic cpu_gnt, host_gnt;
  logic cpu_rvalid, host_rvalid;
  logic unused_addr;

  assign both        = bus.cpu_req & bus.host_req;
  assign lock_active = (lock_q == LOCKED);

  arb_starve_cnt #(
    .MAX (MAX_WAIT)
  ) u_starve (
    .clk    (clk),
    .rst    (rst),
    .inc    (bus.host_req & ~host_gnt),
    .clr    (host_gnt | ~bus.host_req),
    .at_max (at_max)
  );

  // yield_q hands one contended cycle to the cpu after a lock
  // expiry; resume_q then lets the still-locking host back in
  always_comb begin
    cpu_gnt  = 1'b0;
    host_gnt = 1'b0;
    if (!rst) begin
      if (lock_active && bus.host_req) begin
        host_gnt = 1'b1;
      end else if (both) begin
        if (yield_q) begin
          cpu_gnt = 1'b1;
        end else if (resume_q && bus.host_lock) begin
          host_gnt = 1'b1;
        end else if (at_max) begin
          host_gnt = 1'b1;
        end else begin
          cpu_gnt = 1'b1;
        end
      end else begin
        cpu_gnt  = bus.cpu_req;
        host_gnt = bus.host_req;
      end
    end
  end

  assign bus.cpu_gnt   = cpu_gnt;
  assign bus.host_gnt  = host_gnt;
  assign bus.cpu_stall = bus.cpu_req & ~cpu_gnt;

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_be    = '0;
    unique case (1'b1)
      cpu_gnt: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = bus.cpu_we;
        bus.mem_addr  = bus.cpu_addr[AW+1:2];
        bus.mem_wdata = bus.cpu_wdata;
        bus.mem_be    = bus.cpu_be;
      end
      host_gnt: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = bus.host_we;
        bus.mem_addr  = bus.host_addr[AW+1:2];
        bus.mem_wdata = bus.host_wdata;
        bus.mem_be    = bus.host_be;
      end
      default: ;
    endcase
  end

  assign unused_addr = ^{bus.cpu_addr[31:AW+2],
                         bus.cpu_addr[1:0],
                         bus.host_addr[31:AW+2],
                         bus.host_addr[1:0]};

  always_comb begin
    lock_d     = lock_q;
    lock_cnt_d = lock_cnt_q;
    yield_d    = yield_q & bus.host_lock
               & bus.host_req & ~host_gnt & ~cpu_gnt;
    resume_d   = bus.host_lock & bus.host_req
               & ~host_gnt
               & (resume_q | (yield_q & cpu_gnt));
    case (lock_q)
      UNLOCKED: begin
        if (host_gnt && bus.host_lock) begin
          lock_d     = LOCKED;
          lock_cnt_d = LW'(1);
        end
      end
      LOCKED: begin
        if (!bus.host_lock) begin
          lock_d     = UNLOCKED;
          lock_cnt_d = '0;
        end else if (host_gnt) begin
          if (lock_cnt_q == LOCK_LAST) begin
            lock_d     = UNLOCKED;
            lock_cnt_d = '0;
            yield_d    = 1'b1;
          end else begin
            lock_cnt_d = lock_cnt_q + 1'b1;
          end
        end
      end
      default: lock_d = UNLOCKED;
    endcase
  end

  assign cpu_rvalid  = rd_pend_q & (rd_owner_q == OWN_CPU);
  assign host_rvalid = rd_pend_q & (rd_owner_q == OWN_HOST);

  always_comb begin
    rd_pend_d    = (cpu_gnt & ~bus.cpu_we)
                 | (host_gnt & ~bus.host_we);
    rd_owner_d   = host_gnt ? OWN_HOST : OWN_CPU;
    cpu_rdata_d  = cpu_rvalid ? bus.mem_rdata : cpu_rdata_q;
    host_rdata_d = host_rvalid ? bus.mem_rdata : host_rdata_q;
  end

  assign bus.cpu_rvalid  = cpu_rvalid;
  assign bus.host_rvalid = host_rvalid;
  assign bus.cpu_rdata   = cpu_rdata_d;
  assign bus.host_rdata  = host_rdata_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q       <= UNLOCKED;
      lock_cnt_q   <= '0;
      yield_q      <= 1'b0;
      resume_q     <= 1'b0;
      rd_pend_q    <= 1'b0;
      rd_owner_q   <= OWN_CPU;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      lock_q       <= lock_d;
      lock_cnt_q   <= lock_cnt_d;
      yield_q      <= yield_d;
      resume_q     <= resume_d;
      rd_pend_q    <= rd_pend_d;
      rd_owner_q   <= rd_owner_d;
      cpu_rdata_q  <= cpu_rdata_d;
      host_rdata_q <= host_rdata_d;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic        forced;
  logic [15:0] conflict_q, conflict_d;
  logic [15:0] forced_q, forced_d;

  assign forced = host_gnt & both & ~lock_active
                & ~yield_q & ~(resume_q & bus.host_lock);

  always_comb begin
    conflict_d = conflict_q;
    forced_d   = forced_q;
    if (both && conflict_q != 16'hFFFF) begin
      conflict_d = conflict_q + 16'd1;
    end
    if (forced && forced_q != 16'hFFFF) begin
      forced_d = forced_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_q <= '0;
      forced_q   <= '0;
    end else begin
      conflict_q <= conflict_d;
      forced_q   <= forced_d;
    end
  end

  assign conflict_cnt = conflict_q;
  assign forced_cnt   = forced_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: vector table plus sequences
// for reads, lock bursts, alternating owners and reset mid-read.
module tb_dmem_arbiter;
  import mips_mem_pkg::*;

  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;

  dmem_arbiter_if #(.AW(AW)) bus ();

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] conflict_cnt;
  logic [15:0] forced_cnt;
`endif

  dmem_arbiter #(
    .AW       (AW),
    .MAX_WAIT (4),
    .MAX_LOCK (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef DMEM_ARB_STATS_EN
    ,
    .conflict_cnt (conflict_cnt),
    .forced_cnt   (forced_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] mem [1024];
  logic [31:0] rd_q;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (bus.mem_be[b]) begin
            mem[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
          end
        end
      end else begin
        rd_q <= mem[bus.mem_addr];
      end
    end
  end

  assign bus.mem_rdata = rd_q;

  typedef struct {
    logic        c_req;
    logic        c_we;
    logic [31:0] c_addr;
    logic        h_req;
    logic        h_we;
    logic [31:0] h_addr;
    logic        e_cg;
    logic        e_hg;
    logic        e_stall;
    logic        e_mwe;
    logic [9:0]  e_maddr;
    logic        e_crv;
    logic        e_hrv;
  } vec_t;

  function automatic vec_t mk(
    input logic c_req, input logic c_we,
    input logic [31:0] c_addr,
    input logic h_req, input logic h_we,
    input logic [31:0] h_addr,
    input logic e_cg, input logic e_hg,
    input logic e_stall, input logic e_mwe,
    input logic [9:0] e_maddr,
    input logic e_crv, input logic e_hrv);
    vec_t v;
    v.c_req = c_req;  v.c_we = c_we;  v.c_addr = c_addr;
    v.h_req = h_req;  v.h_we = h_we;  v.h_addr = h_addr;
    v.e_cg = e_cg;    v.e_hg = e_hg;  v.e_stall = e_stall;
    v.e_mwe = e_mwe;  v.e_maddr = e_maddr;
    v.e_crv = e_crv;  v.e_hrv = e_hrv;
    return v;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %08h expected %08h",
               name, act, exp);
    end else begin
      passed++;
    end
  endtask

  task automatic set_cpu(input logic req, input logic we,
                         input logic [31:0] addr,
                         input logic [31:0] wdata,
                         input logic [3:0] be);
    bus.cpu_req   = req;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    bus.cpu_be    = be;
  endtask

  task automatic set_host(input logic req, input logic we,
                          input logic [31:0] addr,
                          input logic [31:0] wdata,
                          input logic [3:0] be,
                          input logic lock);
    bus.host_req   = req;
    bus.host_we    = we;
    bus.host_addr  = addr;
    bus.host_wdata = wdata;
    bus.host_be    = be;
    bus.host_lock  = lock;
  endtask

  task automatic idle();
    set_cpu(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_host(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic host_write(input logic [31:0] addr,
                            input logic [31:0] data);
    @(negedge clk);
    set_cpu(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_host(1'b1, 1'b1, addr, data, 4'hF, 1'b0);
  endtask

  vec_t tbl [10];
  int   stalls;
  int   hgnts;
  logic [1:0] exp_g;

  initial begin
    idle();

    // starve: v3..v6 cpu wins, v7 is the forced host grant
    tbl[0] = mk(0,0,32'h0,        0,0,32'h0,    0,0,0,0,10'h000,0,0);
    tbl[1] = mk(1,0,32'h110,      0,0,32'h0,    1,0,0,0,10'h044,0,0);
    tbl[2] = mk(0,0,32'h0,        1,1,32'h100,  0,1,0,1,10'h040,1,0);
    tbl[3] = mk(1,0,32'h4,        1,0,32'h8,    1,0,0,0,10'h001,0,0);
    tbl[4] = mk(1,0,32'h4,        1,0,32'h8,    1,0,0,0,10'h001,1,0);
    tbl[5] = mk(1,0,32'h4,        1,0,32'h8,    1,0,0,0,10'h001,1,0);
    tbl[6] = mk(1,0,32'h4,        1,0,32'h8,    1,0,0,0,10'h001,1,0);
    tbl[7] = mk(1,0,32'h4,        1,0,32'h8,    0,1,1,0,10'h002,1,0);
    tbl[8] = mk(0,0,32'h0,        1,0,32'h1004, 0,1,0,0,10'h001,0,1);
    tbl[9] = mk(1,0,32'hFFFFFFFC, 0,0,32'h0,    1,0,0,0,10'h3FF,0,1);

    do_reset();
    #2;
    chk("reset cpu_gnt", 32'(bus.cpu_gnt), 32'd0);
    chk("reset mem_en", 32'(bus.mem_en), 32'd0);
    chk("reset cpu_rdata", bus.cpu_rdata, 32'h0);
    chk("reset host_rdata", bus.host_rdata, 32'h0);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      set_cpu(tbl[i].c_req, tbl[i].c_we, tbl[i].c_addr,
              32'h0, 4'hF);
      set_host(tbl[i].h_req, tbl[i].h_we, tbl[i].h_addr,
               32'hA5A50000 | 32'(i), 4'hF, 1'b0);
      #2;
      chk($sformatf("v%0d cpu_gnt", i),
          32'(bus.cpu_gnt), 32'(tbl[i].e_cg));
      chk($sformatf("v%0d host_gnt", i),
          32'(bus.host_gnt), 32'(tbl[i].e_hg));
      chk($sformatf("v%0d cpu_stall", i),
          32'(bus.cpu_stall), 32'(tbl[i].e_stall));
      chk($sformatf("v%0d mem_we", i),
          32'(bus.mem_we), 32'(tbl[i].e_mwe));
      chk($sformatf("v%0d mem_addr", i),
          32'(bus.mem_addr), 32'(tbl[i].e_maddr));
      chk($sformatf("v%0d cpu_rvalid", i),
          32'(bus.cpu_rvalid), 32'(tbl[i].e_crv));
      chk($sformatf("v%0d host_rvalid", i),
          32'(bus.host_rvalid), 32'(tbl[i].e_hrv));
    end

    // cpu-only read with known word
    do_reset();
    host_write(32'h110, 32'hABCD7FAF);
    @(negedge clk);
    idle();
    set_cpu(1'b1, 1'b0, 32'h110, 32'h0, 4'hF);
    #2;
    chk("rd cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
    chk("rd cpu_stall", 32'(bus.cpu_stall), 32'd0);
    chk("rd mem_addr", 32'(bus.mem_addr), 32'h44);
    @(negedge clk);
    idle();
    #2;
    chk("rd cpu_rvalid", 32'(bus.cpu_rvalid), 32'd1);
    chk("rd cpu_rdata", bus.cpu_rdata, 32'hABCD7FAF);
    chk("rd host_rvalid", 32'(bus.host_rvalid), 32'd0);

    // byte write to OUT0
    host_write(32'(OUT0_ADDR), 32'h12345678);
    @(negedge clk);
    idle();
    set_host(1'b1, 1'b1, 32'(OUT0_ADDR), 32'h000000AF,
             4'b0001, 1'b0);
    #2;
    chk("wr host_gnt", 32'(bus.host_gnt), 32'd1);
    chk("wr mem_we", 32'(bus.mem_we), 32'd1);
    chk("wr mem_be", 32'(bus.mem_be), 32'h1);
    chk("wr mem_addr", 32'(bus.mem_addr), 32'd64);
    chk("wr mem_wdata", bus.mem_wdata, 32'h000000AF);
    @(negedge clk);
    set_host(1'b1, 1'b0, 32'(OUT0_ADDR), 32'h0, 4'hF, 1'b0);
    #2;
    chk("wr no host_rvalid", 32'(bus.host_rvalid), 32'd0);
    chk("wr no cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    @(negedge clk);
    idle();
    #2;
    chk("wr readback rvalid", 32'(bus.host_rvalid), 32'd1);
    chk("wr readback data", bus.host_rdata, 32'h123456AF);

    // alternating owners on consecutive reads
    host_write(32'h0, 32'h11111111);
    host_write(32'h100, 32'h22222222);
    @(negedge clk);
    idle();
    set_cpu(1'b1, 1'b0, 32'h0, 32'h0, 4'hF);
    #2;
    chk("alt cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
    @(negedge clk);
    idle();
    set_host(1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 1'b0);
    #2;
    chk("alt host_gnt", 32'(bus.host_gnt), 32'd1);
    chk("alt cpu_rvalid", 32'(bus.cpu_rvalid), 32'd1);
    chk("alt cpu_rdata", bus.cpu_rdata, 32'h11111111);
    chk("alt host_rvalid early", 32'(bus.host_rvalid), 32'd0);
    @(negedge clk);
    idle();
    #2;
    chk("alt host_rvalid", 32'(bus.host_rvalid), 32'd1);
    chk("alt host_rdata", bus.host_rdata, 32'h22222222);
    chk("alt cpu_rvalid late", 32'(bus.cpu_rvalid), 32'd0);
    chk("alt cpu_rdata hold", bus.cpu_rdata, 32'h11111111);

    // lock burst: 4 cpu, 16 host, 1 cpu yield, host re-locks
    do_reset();
    stalls = 0;
    hgnts  = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (c == 0) begin
        set_cpu(1'b1, 1'b0, 32'h4, 32'h0, 4'hF);
        set_host(1'b1, 1'b1, 32'h200, 32'hC0DE0000,
                 4'hF, 1'b1);
      end
      #2;
      exp_g = (c < 4 || c == 20) ? 2'b10 : 2'b01;
      chk($sformatf("lock c%0d gnt", c),
          32'({bus.cpu_gnt, bus.host_gnt}), 32'(exp_g));
      if (c >= 4 && c <= 20 && bus.cpu_stall) stalls++;
      if (bus.host_gnt) hgnts++;
    end
    chk("lock stall cycles", 32'(stalls), 32'd16);
    chk("lock host grants", 32'(hgnts), 32'd20);

    // reset right after a granted cpu read, lock held
    do_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      set_cpu(1'b1, 1'b0, 32'h4, 32'h0, 4'hF);
      set_host(1'b1, 1'b1, 32'h200, 32'h0, 4'hF, 1'b1);
    end
    @(negedge clk);
    set_cpu(1'b1, 1'b0, 32'h110, 32'h0, 4'hF);
    set_host(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    #2;
    chk("rst pre cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
    chk("rst pre locked", 32'(dut.lock_q), 32'(LOCKED));
    @(posedge clk);
    #1;
    idle();
    rst = 1'b1;
    #1;
    chk("rst during cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    chk("rst during mem_en", 32'(bus.mem_en), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("rst after cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    chk("rst after starve", 32'(dut.u_starve.cnt_q), 32'd0);
    chk("rst after unlocked", 32'(dut.lock_q), 32'(UNLOCKED));
    @(negedge clk);
    set_cpu(1'b1, 1'b0, 32'h4, 32'h0, 4'hF);
    set_host(1'b1, 1'b1, 32'h200, 32'h0, 4'hF, 1'b1);
    #2;
    chk("rst after gnt", 32'({bus.cpu_gnt, bus.host_gnt}),
        32'(2'b10));
    chk("rst after no rvalid", 32'(bus.cpu_rvalid), 32'd0);

    @(negedge clk);
    idle();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
